// File: rtl/in_port_debouncer.sv
// Input port conditioning: 2-flop synchronizer plus a per-bit stability
// counter, with registered edge pulses and a change strobe.
module in_port_debouncer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   // A single-cycle debounce still needs a 1-bit counter to exist.
   localparam int CNT_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
         $error("in_port_debouncer: DEBOUNCE_CYCLES must be 1..255");
      end
   endgenerate

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] differ;
   logic [WIDTH-1:0] accept;

   always_comb begin
      differ = sync2 ^ in;
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = differ[i] && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!differ[i] || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Pulses are registered alongside in so they line up with the new value.
   always_ff @(posedge clock) begin
      if (reset) begin
         in      <= '0;
         rise    <= '0;
         fall    <= '0;
         changed <= 1'b0;
      end else begin
         in      <= (in & ~accept) | (sync2 & accept);
         rise    <= accept & sync2;
         fall    <= accept & ~sync2;
         changed <= |accept;
      end
   end

endmodule
